instr_mem_sync: RTL and testbench

Parametrised synchronous instruction memory for the pipelined CPU's IF stage.
- Read is registered: one-cycle latency, with a `req_i`/`valid_o` handshake and a stall hold.
- Program-load write port for bench or boot loading.
- Misaligned and out-of-range fetches are detected and substituted with NOP.
- Saturating counter of accepted fetches for CPI measurement.

---
 rtl/instr_mem_sync.sv | 119 +++++++++++
 tb/tb_instr_mem_sync.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous instruction memory for the IF stage.
//
// Registered read with one-cycle latency, a req/valid handshake and a
// stall hold.  A separate write port loads the program.  A saturating
// counter tracks accepted fetches for CPI measurement.
//
// Optional feature macro: INSTR_MEM_FAULT_EN
//   defined   : misaligned or out-of-range fetches return NOP (0) with
//               fault_o=1; out-of-range writes are dropped.
//   undefined : fault_o is tied 0; the low address bits are ignored and
//               word indices wrap modulo DEPTH for reads and writes.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   req_i        fetch request
//   addr_i       fetch byte address
//   stall_i      consumer not ready; holds the output register
//   instr_o      fetched instruction (registered)
//   valid_o      instr_o holds an accepted fetch
//   fault_o      fetch in instr_o faulted (qualified by valid_o)
//   wr_en_i      program-load write enable
//   wr_addr_i    write byte address
//   wr_data_i    write data
//   fetch_cnt_o  accepted fetch count, saturating
module instr_mem_sync #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 32,
    parameter int    ADDR_W    = 32,
    parameter string INIT_FILE = "",
    parameter int    CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              stall_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              valid_o,
    output logic              fault_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is not touched by reset: it is zeroed once at time zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    logic [ADDR_W-3:0] rd_word;
    logic [ADDR_W-3:0] wr_word;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_ok;
    logic              fault_det;
    logic              unused_bits;

    assign rd_word = addr_i[ADDR_W-1:2];
    assign wr_word = wr_addr_i[ADDR_W-1:2];

`ifdef INSTR_MEM_FAULT_EN
    // Index is only meaningful when in range; a faulting fetch never
    // uses the read data.
    assign rd_idx      = rd_word[IDX_W-1:0];
    assign wr_idx      = wr_word[IDX_W-1:0];
    assign wr_ok       = (wr_word < DEPTH_W);
    assign fault_det   = (addr_i[1:0] != 2'b00) || (rd_word >= DEPTH_W);
    assign unused_bits = ^wr_addr_i[1:0];
`else
    assign rd_idx      = IDX_W'(rd_word % DEPTH_W);
    assign wr_idx      = IDX_W'(wr_word % DEPTH_W);
    assign wr_ok       = 1'b1;
    assign fault_det   = 1'b0;
    assign unused_bits = ^{addr_i[1:0], wr_addr_i[1:0]};
`endif

    logic              wr_fire;
    logic [DATA_W-1:0] rd_data;
    logic              accept;
    logic              hold;

    assign wr_fire = wr_en_i && wr_ok;
    // Write-first: a same-edge write to the fetched word bypasses storage.
    assign rd_data = (wr_fire && (wr_idx == rd_idx)) ? wr_data_i : mem[rd_idx];
    assign hold    = stall_i && valid_o;
    assign accept  = req_i && !hold;

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem[wr_idx] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_o     <= '0;
            valid_o     <= 1'b0;
            fault_o     <= 1'b0;
            fetch_cnt_o <= '0;
        end else begin
            if (accept) begin
                instr_o <= fault_det ? '0 : rd_data;
                valid_o <= 1'b1;
                fault_o <= fault_det;
                if (fetch_cnt_o != CNT_MAX) fetch_cnt_o <= fetch_cnt_o + 1'b1;
            end else if (!hold) begin
                // No request: drop valid, keep the last word and fault flag.
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
module tb_instr_mem_sync;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
`ifdef INSTR_MEM_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              req_i = 1'b0;
    logic              stall_i = 1'b0;
    logic              wr_en_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [ADDR_W-1:0] wr_addr_i = '0;
    logic [DATA_W-1:0] wr_data_i = '0;
    logic [DATA_W-1:0] instr_o;
    logic              valid_o;
    logic              fault_o;
    logic [CNT_W-1:0]  fetch_cnt_o;

    instr_mem_sync #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_FILE(""), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
        .stall_i(stall_i), .instr_o(instr_o), .valid_o(valid_o),
        .fault_o(fault_o), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req;
        logic        stall;
        logic [31:0] addr;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_fault;
        logic [3:0]  e_cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[19];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic req, logic stall, logic [31:0] addr,
                                logic we, logic [31:0] waddr, logic [31:0] wdata,
                                logic [31:0] ei, logic ev, logic ef, logic [3:0] ec);
        vec_t v;
        v.req = req; v.stall = stall; v.addr = addr;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.e_instr = ei; v.e_valid = ev; v.e_fault = ef; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(exp_t e);
        chk({e.name, ".valid"}, 32'(valid_o), 32'(e.valid));
        chk({e.name, ".instr"}, instr_o, e.instr);
        chk({e.name, ".fault"}, 32'(fault_o), 32'(e.fault));
        chk({e.name, ".cnt"}, 32'(fetch_cnt_o), 32'(e.cnt));
    endtask

    // Called at a negedge: drive, push expectation, wait one cycle, pop/compare.
    task automatic step(vec_t v, string nm);
        exp_t e;
        req_i = v.req; stall_i = v.stall; addr_i = v.addr;
        wr_en_i = v.we; wr_addr_i = v.waddr; wr_data_i = v.wdata;
        e.name = nm; e.instr = v.e_instr; e.valid = v.e_valid;
        e.fault = v.e_fault; e.cnt = v.e_cnt;
        sb.push_back(e);
        @(negedge clk_i);
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            chk_outs(sb.pop_front());
        end
    endtask

    initial begin
        exp_t r;
        logic [3:0] cnt_m;

        // Load program, then fetch/stall/write-first/fault/wrap cases.
        tbl[0]  = mk(0,0,0,  1,0,  32'h2001000A, 32'h0,        0,0,0);
        tbl[1]  = mk(0,0,0,  1,4,  32'h20020003, 32'h0,        0,0,0);
        tbl[2]  = mk(1,0,0,  0,0,  0,            32'h2001000A, 1,0,1);
        tbl[3]  = mk(1,0,4,  0,0,  0,            32'h20020003, 1,0,2);
        tbl[4]  = mk(1,0,0,  0,0,  0,            32'h2001000A, 1,0,3);
        tbl[5]  = mk(1,1,4,  0,0,  0,            32'h2001000A, 1,0,3);
        tbl[6]  = mk(1,1,4,  0,0,  0,            32'h2001000A, 1,0,3);
        tbl[7]  = mk(1,1,4,  0,0,  0,            32'h2001000A, 1,0,3);
        tbl[8]  = mk(1,0,4,  0,0,  0,            32'h20020003, 1,0,4);
        tbl[9]  = mk(0,0,0,  0,0,  0,            32'h20020003, 0,0,4);
        tbl[10] = mk(0,1,0,  0,0,  0,            32'h20020003, 0,0,4);
        tbl[11] = mk(1,1,0,  0,0,  0,            32'h2001000A, 1,0,5);
        tbl[12] = mk(1,0,8,  1,8,  32'hDEADBEEF, 32'hDEADBEEF, 1,0,6);
        tbl[13] = mk(1,0,8,  0,0,  0,            32'hDEADBEEF, 1,0,7);
        tbl[14] = mk(1,0,6,  0,0,  0,            FE ? 32'h0 : 32'h20020003, 1,FE,8);
        tbl[15] = mk(1,0,128,0,0,  0,            FE ? 32'h0 : 32'h2001000A, 1,FE,9);
        tbl[16] = mk(0,0,0,  1,128,32'h11111111, FE ? 32'h0 : 32'h2001000A, 0,FE,9);
        tbl[17] = mk(1,0,0,  0,0,  0,            FE ? 32'h2001000A : 32'h11111111, 1,0,10);
        tbl[18] = mk(0,0,0,  0,0,  0,            FE ? 32'h2001000A : 32'h11111111, 0,0,10);

        // Reset state, held across clock edges.
        repeat (2) @(negedge clk_i);
        r.name = "reset"; r.instr = 0; r.valid = 0; r.fault = 0; r.cnt = 0;
        chk_outs(r);
        rst_i = 1'b1;

        for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("row%0d", i));

        // Saturation: keep fetching until the 4-bit counter pins at 15.
        cnt_m = 4'd10;
        for (int i = 0; i < 10; i++) begin
            cnt_m = (cnt_m == 4'd15) ? 4'd15 : cnt_m + 4'd1;
            step(mk(1,0,4,0,0,0, 32'h20020003,1,0,cnt_m), $sformatf("sat%0d", i));
        end

        // Asynchronous reset while stalled with valid output.
        req_i = 1'b1; stall_i = 1'b1; addr_i = 0; wr_en_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        r.name = "async_rst"; r.instr = 0; r.valid = 0; r.fault = 0; r.cnt = 0;
        chk_outs(r);
        @(posedge clk_i); #1;
        r.name = "rst_hold";
        chk_outs(r);
        @(negedge clk_i);
        rst_i = 1'b1; req_i = 1'b0; stall_i = 1'b0;
        @(negedge clk_i);

        // Storage survives reset.
        step(mk(1,0,8,0,0,0, 32'hDEADBEEF,1,0,1), "post0");
        step(mk(1,0,4,0,0,0, 32'h20020003,1,0,2), "post1");
        step(mk(1,0,0,0,0,0, FE ? 32'h2001000A : 32'h11111111,1,0,3), "post2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
